// File: rtl/wb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_pkg                                                             |
// | Shared source encodings, default widths and grant helpers for the  |
// | write-back arbiter.                                                |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package wb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        SRC_ADD    = 2'b00,
        SRC_MULT   = 2'b01,
        SRC_MULADD = 2'b10
    } src_e;

    // Lowest set bit wins; result is one-hot or zero.
    function automatic logic [2:0] pri3(input logic [2:0] req);
        logic [2:0] g;
        g = 3'b000;
        if (req[0])      g = 3'b001;
        else if (req[1]) g = 3'b010;
        else if (req[2]) g = 3'b100;
        return g;
    endfunction

    function automatic src_e gnt_to_src(input logic [2:0] gnt);
        src_e s;
        s = SRC_ADD;
        if (gnt[2])      s = SRC_MULADD;
        else if (gnt[1]) s = SRC_MULT;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb3.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arb3                                                            |
// | Three-request one-hot arbiter. WB_ARB_RR_EN selects round-robin    |
// | with a pointer register; otherwise fixed priority 0 > 1 > 2.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rr_arb3
    import wb_pkg::*;
(
`ifdef WB_ARB_RR_EN
    input  logic       clk,
    input  logic       rst_n,
`endif
    input  logic [2:0] req_i,
    input  logic       hold_i,
    output logic [2:0] gnt_o
);

`ifdef WB_ARB_RR_EN
    src_e       ptr_q;
    src_e       ptr_d;
    logic [2:0] rot_w;
    logic [2:0] pg_w;
    logic [2:0] gnt_w;

    // Rotate requests so the pointer source sits at bit 0, pick, rotate back.
    always_comb begin
        rot_w = req_i;
        pg_w  = 3'b000;
        gnt_w = 3'b000;
        case (ptr_q)
            SRC_MULT: begin
                rot_w = {req_i[0], req_i[2], req_i[1]};
                pg_w  = pri3(rot_w);
                gnt_w = {pg_w[1], pg_w[0], pg_w[2]};
            end
            SRC_MULADD: begin
                rot_w = {req_i[1], req_i[0], req_i[2]};
                pg_w  = pri3(rot_w);
                gnt_w = {pg_w[0], pg_w[2], pg_w[1]};
            end
            default: begin
                pg_w  = pri3(rot_w);
                gnt_w = pg_w;
            end
        endcase
        gnt_o = hold_i ? 3'b000 : gnt_w;

        ptr_d = ptr_q;
        if (gnt_o[0])      ptr_d = SRC_MULT;
        else if (gnt_o[1]) ptr_d = SRC_MULADD;
        else if (gnt_o[2]) ptr_d = SRC_ADD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= SRC_ADD;
        else        ptr_q <= ptr_d;
    end
`else
    always_comb begin
        gnt_o = hold_i ? 3'b000 : pri3(req_i);
    end
`endif

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_arbiter                                                         |
// | Merges ADD/MULT/MULADD results into one register-file write port.  |
// | Optional macro: WB_ARB_RR_EN (round-robin instead of fixed prio).  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              add_valid,
    input  logic              mult_valid,
    input  logic              muladd_valid,
    output logic              add_ready,
    output logic              mult_ready,
    output logic              muladd_ready,
    input  logic [ADDR_W-1:0] add_rd,
    input  logic [ADDR_W-1:0] mult_rd,
    input  logic [ADDR_W-1:0] muladd_rd,
    input  logic [DATA_W-1:0] add_data,
    input  logic [DATA_W-1:0] mult_data,
    input  logic [DATA_W-1:0] muladd_data,
    input  logic              wb_hold,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [1:0]        rd_sel
);

    logic [2:0]        valid_w, gnt_w, ready_w, acc_w;
    logic [2:0]        full_q, full_d;
    logic [ADDR_W-1:0] in_rd_w [3];
    logic [ADDR_W-1:0] rd_q    [3];
    logic [ADDR_W-1:0] rd_d    [3];
    logic [DATA_W-1:0] in_data_w [3];
    logic [DATA_W-1:0] data_q    [3];
    logic [DATA_W-1:0] data_d    [3];

    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    src_e              rd_sel_q, rd_sel_d;
    src_e              sel_w;
    logic [ADDR_W-1:0] mux_rd_w;
    logic [DATA_W-1:0] mux_data_w;

    assign valid_w      = {muladd_valid, mult_valid, add_valid};
    assign in_rd_w[0]   = add_rd;
    assign in_rd_w[1]   = mult_rd;
    assign in_rd_w[2]   = muladd_rd;
    assign in_data_w[0] = add_data;
    assign in_data_w[1] = mult_data;
    assign in_data_w[2] = muladd_data;

    rr_arb3 u_arb (
`ifdef WB_ARB_RR_EN
        .clk    (clk),
        .rst_n  (rst_n),
`endif
        .req_i  (full_q),
        .hold_i (wb_hold),
        .gnt_o  (gnt_w)
    );

    // A slot draining this cycle can be refilled on the same edge.
    assign ready_w      = rst_n ? (~full_q | gnt_w) : 3'b000;
    assign acc_w        = valid_w & ready_w;
    assign add_ready    = ready_w[0];
    assign mult_ready   = ready_w[1];
    assign muladd_ready = ready_w[2];

    always_comb begin
        full_d = full_q;
        rd_d   = rd_q;
        data_d = data_q;
        for (int i = 0; i < 3; i++) begin
            if (acc_w[i]) begin
                full_d[i] = 1'b1;
                rd_d[i]   = in_rd_w[i];
                data_d[i] = in_data_w[i];
            end else if (gnt_w[i]) begin
                full_d[i] = 1'b0;
            end
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_slot
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                full_q[i] <= 1'b0;
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end else begin
                full_q[i] <= full_d[i];
                rd_q[i]   <= rd_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    always_comb begin
        sel_w = gnt_to_src(gnt_w);
        case (sel_w)
            SRC_MULT: begin
                mux_rd_w   = rd_q[1];
                mux_data_w = data_q[1];
            end
            SRC_MULADD: begin
                mux_rd_w   = rd_q[2];
                mux_data_w = data_q[2];
            end
            default: begin
                mux_rd_w   = rd_q[0];
                mux_data_w = data_q[0];
            end
        endcase

        rf_we_d    = |gnt_w;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        rd_sel_d   = rd_sel_q;
        if (rf_we_d) begin
            rf_waddr_d = mux_rd_w;
            rf_wdata_d = mux_data_w;
            rd_sel_d   = sel_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            rd_sel_q   <= SRC_ADD;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            rd_sel_q   <= rd_sel_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign rd_sel   = rd_sel_q;

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32: result data width.
REQ-002 SHALL have parameter ADDR_W, default 5: destination register address width.
REQ-003 SHALL use one clock and an asynchronous active-low reset: clk, rst_n.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports add_valid/mult_valid/muladd_valid  input  1 each  result offered by the ADD/MULT/MULADD unit.
REQ-007 SHALL have ports add_ready/mult_ready/muladd_ready  output  1 each  arbiter can take that unit's result.
REQ-008 SHALL have ports add_rd/mult_rd/muladd_rd  input  ADDR_W each  destination register of the offered result.
REQ-009 SHALL have ports add_data/mult_data/muladd_data  input  DATA_W each  offered result value.
REQ-010 SHALL have port wb_hold  input  1  register file busy; no new grant while high.
REQ-011 SHALL have port rf_we  output  1  register file write enable.
REQ-012 SHALL have port rf_waddr  output  ADDR_W  write address.
REQ-013 SHALL have port rf_wdata  output  DATA_W  write data.
REQ-014 SHALL have port rd_sel  output  2  source of the current write: 00 ADD, 01 MULT, 10 MULADD.

Function
REQ-015 SHALL hold one result slot (full flag, rd, data) per source.
REQ-016 SHALL accept a result on a rising edge where valid and ready are both high; the slot becomes full after that edge.
REQ-017 SHALL drive ready = slot empty OR slot granted in the current cycle, so one result per source per cycle can be sustained.
REQ-018 SHALL, while wb_hold is low, grant exactly one full slot per cycle; when wb_hold is high it grants nothing and every slot holds.
REQ-019 SHALL, on the edge after a grant, register rf_we=1, rf_waddr, rf_wdata and rd_sel from the granted slot, and clear that slot unless it is refilled on the same edge.
REQ-020 SHALL drive rf_we=0 on any cycle that follows a cycle with no grant; rf_waddr, rf_wdata and rd_sel then keep their last values.
REQ-021 SHALL give a minimum latency of 2 edges from the input handshake edge to rf_we high, with no combinational path from any input to any output except the ready signals.
REQ-022 SHALL serialise simultaneous results in arbitration order, including results with identical rd; the later write wins in the register file.
REQ-023 SHALL never drop or duplicate an accepted result; each accepted result produces exactly one rf_we pulse.
REQ-024 SHALL hold rd_sel to 00, 01 or 10 only; 11 is never driven.

Reset
REQ-025 SHALL, on rst_n low (asynchronous), clear all slots, rf_we=0, rf_waddr=0, rf_wdata=0, rd_sel=00, and reset the arbitration pointer to ADD.
REQ-026 SHALL discard pending slot contents when reset is asserted mid-operation; all ready signals are low during reset and high on the first cycle after it.

Configuration
REQ-027 SHALL support macro WB_ARB_RR_EN. When defined, arbitration is round-robin: the priority starts at the source after the last granted one, cycling ADD, MULT, MULADD.
REQ-028 SHALL, when WB_ARB_RR_EN is undefined, use fixed priority ADD > MULT > MULADD, with no pointer state.

Structure
REQ-029 SHALL take the rd_sel encodings (SRC_ADD=2'b00, SRC_MULT=2'b01, SRC_MULADD=2'b10) and the default widths from shared package wb_pkg, which is also used by the destination-select mux.
REQ-030 SHALL place grant logic in one sub-module, rr_arb3: 3 requests, one-hot grant, pointer state present only under WB_ARB_RR_EN.

Verification
REQ-031 SHALL cover: single ADD result rd=5, data=0x0000_00AA -> 2 edges later rf_we=1, rf_waddr=5, rf_wdata=0xAA, rd_sel=00 for exactly one cycle.
REQ-032 SHALL cover: all three valid in the same cycle (rd 1/2/3), with RR -> writes to 1, 2, 3 on consecutive cycles with rd_sel 00, 01, 10; without RR the order is the same and ADD repeatedly offering starves MULT.
REQ-033 SHALL cover: wb_hold high for 4 cycles with all slots full -> rf_we=0, all ready=0, then three writes after release and no loss.
REQ-034 SHALL cover: MULT streaming valid every cycle alone -> mult_ready stays 1 and rf_we=1 every cycle after the 2-edge fill.
REQ-035 SHALL cover: rst_n low while two slots are full -> immediate rf_we=0 and rd_sel=00, and no write of the pending results after reset.
REQ-036 SHALL cover: ADD and MULADD both target rd=7 simultaneously (RR, pointer at ADD) -> two writes to 7, MULADD's data last.
